// File: rtl/vid_pattern_gen.sv
`default_nettype none
// ============================================================================
//  Module   : vid_pattern_gen
//  Purpose  : Video stream source. Generates raster timing (hsync, vsync,
//             VDE) from programmable counters and drives 24-bit pixel data
//             from a selectable test pattern, so downstream pixel filters
//             can run on a known stream without a live video input.
//  Ports    : clk            pixel clock
//             rst            synchronous, active-high reset
//             i_en           generator enable
//             i_pattern_sel  0 bars, 1 checkerboard, 2 grey ramp, 3 solid
//             i_solid_rgb    colour for pattern 3 (sampled live)
//             o_vid_data     pixel {R,G,B}, zero outside active video
//             o_vid_hsync    horizontal sync (active level SYNC_POL)
//             o_vid_vsync    vertical sync   (active level SYNC_POL)
//             o_vid_VDE      active video
//             o_frame_start  one-cycle pulse with pixel (0,0)
//             o_frame_cnt    completed-frame counter (mod 256)
//  Options  : define SKIN_PATCH_EN to overlay a PATCH_SIZE square of
//             colour E0A080 centred in the active area.
//  Revision : 1.0 - initial release
// ============================================================================
module vid_pattern_gen #(
    parameter int   H_ACTIVE   = 1280,
    parameter int   H_FP       = 110,
    parameter int   H_SYNC     = 40,
    parameter int   H_BP       = 220,
    parameter int   V_ACTIVE   = 720,
    parameter int   V_FP       = 5,
    parameter int   V_SYNC     = 5,
    parameter int   V_BP       = 20,
    parameter logic SYNC_POL   = 1'b1,
    parameter int   CHECK_LOG2 = 5,
    parameter int   PATCH_SIZE = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_en,
    input  logic [1:0]  i_pattern_sel,
    input  logic [23:0] i_solid_rgb,
    output logic [23:0] o_vid_data,
    output logic        o_vid_hsync,
    output logic        o_vid_vsync,
    output logic        o_vid_VDE,
    output logic        o_frame_start,
    output logic [7:0]  o_frame_cnt
);

    function automatic int f_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int c_H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int c_V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    // Counters are wide enough for the checkerboard bit and the 8-bit ramp.
    localparam int c_H_W     = f_max(f_max($clog2(c_H_TOTAL), CHECK_LOG2 + 1), 8);
    localparam int c_V_W     = f_max($clog2(c_V_TOTAL), CHECK_LOG2 + 1);
    localparam int c_BAR_W   = H_ACTIVE / 8;
    localparam int c_BAR_CW  = f_max($clog2(c_BAR_W), 1);

    localparam logic [c_H_W-1:0]    c_H_LAST   = c_H_W'(c_H_TOTAL - 1);
    localparam logic [c_H_W-1:0]    c_H_ACT    = c_H_W'(H_ACTIVE);
    localparam logic [c_H_W-1:0]    c_HS_BEG   = c_H_W'(H_ACTIVE + H_FP);
    localparam logic [c_H_W-1:0]    c_HS_END   = c_H_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [c_V_W-1:0]    c_V_LAST   = c_V_W'(c_V_TOTAL - 1);
    localparam logic [c_V_W-1:0]    c_V_ACT    = c_V_W'(V_ACTIVE);
    localparam logic [c_V_W-1:0]    c_VS_BEG   = c_V_W'(V_ACTIVE + V_FP);
    localparam logic [c_V_W-1:0]    c_VS_END   = c_V_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [c_BAR_CW-1:0] c_BAR_LAST = c_BAR_CW'(c_BAR_W - 1);

    // ------------------------------------------------------------------
    // Run-control FSM. IDLE holds the counters at (0,0) for one enabled
    // cycle so that the first output pixel appears two edges after enable.
    // ------------------------------------------------------------------
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_nxt;
    logic   w_adv;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_adv       = 1'b0;
        if (!i_en) begin
            w_state_nxt = ST_IDLE;
        end else if (r_state == ST_IDLE) begin
            w_state_nxt = ST_RUN;
        end else begin
            w_adv = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Counters and per-position decode
    // ------------------------------------------------------------------
    logic [c_H_W-1:0]    r_h;
    logic [c_V_W-1:0]    r_v;
    logic [2:0]          r_bar;
    logic [c_BAR_CW-1:0] r_bar_cnt;
    logic [1:0]          r_pat;
    logic                r_first;

    logic w_h_last;
    logic w_v_last;
    logic w_vde;
    logic w_hs_on;
    logic w_vs_on;
    logic w_frame_first;

    assign w_h_last      = (r_h == c_H_LAST);
    assign w_v_last      = (r_v == c_V_LAST);
    assign w_vde         = (r_h < c_H_ACT) && (r_v < c_V_ACT);
    assign w_hs_on       = (r_h >= c_HS_BEG) && (r_h < c_HS_END);
    assign w_vs_on       = (r_v >= c_VS_BEG) && (r_v < c_VS_END);
    assign w_frame_first = (r_h == '0) && (r_v == '0);

    logic [23:0] w_pat_pix;
    logic [23:0] w_pix;

    always_comb begin
        w_pat_pix = 24'h000000;
        case (r_pat)
            2'd0: begin
                case (r_bar)
                    3'd0:    w_pat_pix = 24'hFFFFFF;
                    3'd1:    w_pat_pix = 24'hFFFF00;
                    3'd2:    w_pat_pix = 24'h00FFFF;
                    3'd3:    w_pat_pix = 24'h00FF00;
                    3'd4:    w_pat_pix = 24'hFF00FF;
                    3'd5:    w_pat_pix = 24'hFF0000;
                    3'd6:    w_pat_pix = 24'h0000FF;
                    default: w_pat_pix = 24'h000000;
                endcase
            end
            2'd1:    w_pat_pix = (r_h[CHECK_LOG2] ^ r_v[CHECK_LOG2]) ? 24'h000000 : 24'hFFFFFF;
            2'd2:    w_pat_pix = {3{r_h[7:0]}};
            default: w_pat_pix = i_solid_rgb;
        endcase
    end

`ifdef SKIN_PATCH_EN
    localparam int c_PX0 = H_ACTIVE / 2 - PATCH_SIZE / 2;
    localparam int c_PY0 = V_ACTIVE / 2 - PATCH_SIZE / 2;

    logic w_in_patch;

    assign w_in_patch = (r_h >= c_H_W'(c_PX0)) && (r_h < c_H_W'(c_PX0 + PATCH_SIZE)) &&
                        (r_v >= c_V_W'(c_PY0)) && (r_v < c_V_W'(c_PY0 + PATCH_SIZE));
    assign w_pix      = w_in_patch ? 24'hE0A080 : w_pat_pix;
`else
    assign w_pix      = w_pat_pix;
`endif

    // ------------------------------------------------------------------
    // Counter advance and registered outputs
    // ------------------------------------------------------------------
    logic [23:0] r_data;
    logic        r_hs;
    logic        r_vs;
    logic        r_vde;
    logic        r_fs;
    logic [7:0]  r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_h       <= '0;
            r_v       <= '0;
            r_bar     <= '0;
            r_bar_cnt <= '0;
            r_pat     <= 2'd0;
            r_first   <= 1'b1;
            r_data    <= 24'h000000;
            r_hs      <= ~SYNC_POL;
            r_vs      <= ~SYNC_POL;
            r_vde     <= 1'b0;
            r_fs      <= 1'b0;
            r_cnt     <= 8'd0;
        end else if (!i_en) begin
            // Disable aborts the frame; the frame count is kept.
            r_h       <= '0;
            r_v       <= '0;
            r_bar     <= '0;
            r_bar_cnt <= '0;
            r_first   <= 1'b1;
            r_data    <= 24'h000000;
            r_hs      <= ~SYNC_POL;
            r_vs      <= ~SYNC_POL;
            r_vde     <= 1'b0;
            r_fs      <= 1'b0;
        end else if (w_adv) begin
            r_data <= w_vde ? w_pix : 24'h000000;
            r_hs   <= w_hs_on ? SYNC_POL : ~SYNC_POL;
            r_vs   <= w_vs_on ? SYNC_POL : ~SYNC_POL;
            r_vde  <= w_vde;
            r_fs   <= w_frame_first;

            // The first frame after reset/enable is not a completed frame.
            if (w_frame_first) begin
                if (r_first) begin
                    r_first <= 1'b0;
                end else begin
                    r_cnt <= r_cnt + 8'd1;
                end
            end

            // Pattern only changes across a frame boundary.
            if (w_h_last && w_v_last) begin
                r_pat <= i_pattern_sel;
            end

            if (w_h_last) begin
                r_h <= '0;
                r_v <= w_v_last ? '0 : r_v + 1'b1;
            end else begin
                r_h <= r_h + 1'b1;
            end

            // Bar index tracks h / c_BAR_W without a divider, saturating at 7.
            if (w_h_last) begin
                r_bar     <= '0;
                r_bar_cnt <= '0;
            end else if (r_bar_cnt == c_BAR_LAST) begin
                r_bar_cnt <= '0;
                if (r_bar != 3'd7) begin
                    r_bar <= r_bar + 3'd1;
                end
            end else begin
                r_bar_cnt <= r_bar_cnt + 1'b1;
            end
        end
    end

    assign o_vid_data    = r_data;
    assign o_vid_hsync   = r_hs;
    assign o_vid_vsync   = r_vs;
    assign o_vid_VDE     = r_vde;
    assign o_frame_start = r_fs;
    assign o_frame_cnt   = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_vid_pattern_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vid_pattern_gen
//  Purpose  : Self-checking bench for vid_pattern_gen on a small raster
//             (H 16/2/2/2, V 8/1/1/1). A position-based reference model
//             predicts every output each cycle; directed literal checks pin
//             the model at known raster positions. Honours SKIN_PATCH_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_vid_pattern_gen;

    localparam int   HA  = 16, HF = 2, HS = 2, HB = 2;
    localparam int   VA  = 8,  VF = 1, VS = 1, VB = 1;
    localparam int   HT  = HA + HF + HS + HB;
    localparam int   VT  = VA + VF + VS + VB;
    localparam int   FT  = HT * VT;
    localparam logic POL = 1'b1;
    localparam int   CL  = 2;
    localparam int   PS  = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_en;
    logic [1:0]  i_pattern_sel;
    logic [23:0] i_solid_rgb;
    logic [23:0] o_vid_data;
    logic        o_vid_hsync;
    logic        o_vid_vsync;
    logic        o_vid_VDE;
    logic        o_frame_start;
    logic [7:0]  o_frame_cnt;

    always #5 clk = ~clk;

    vid_pattern_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .SYNC_POL(POL), .CHECK_LOG2(CL), .PATCH_SIZE(PS)
    ) u_dut (
        .clk           (clk),
        .rst           (rst),
        .i_en          (i_en),
        .i_pattern_sel (i_pattern_sel),
        .i_solid_rgb   (i_solid_rgb),
        .o_vid_data    (o_vid_data),
        .o_vid_hsync   (o_vid_hsync),
        .o_vid_vsync   (o_vid_vsync),
        .o_vid_VDE     (o_vid_VDE),
        .o_frame_start (o_frame_start),
        .o_frame_cnt   (o_frame_cnt)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: pixel position is a linear index into the frame.
    // ------------------------------------------------------------------
    function automatic logic [23:0] f_pixel(input int h, input int v, input int pat,
                                            input logic [23:0] solid);
        logic [23:0] p;
        int          bar;
        if (!(h < HA && v < VA)) return 24'h000000;
        case (pat)
            0: begin
                bar = h / (HA / 8);
                if (bar > 7) bar = 7;
                case (bar)
                    0: p = 24'hFFFFFF;
                    1: p = 24'hFFFF00;
                    2: p = 24'h00FFFF;
                    3: p = 24'h00FF00;
                    4: p = 24'hFF00FF;
                    5: p = 24'hFF0000;
                    6: p = 24'h0000FF;
                    default: p = 24'h000000;
                endcase
            end
            1: p = ((((h >> CL) ^ (v >> CL)) & 1) == 0) ? 24'hFFFFFF : 24'h000000;
            2: p = {3{8'(h % 256)}};
            default: p = solid;
        endcase
`ifdef SKIN_PATCH_EN
        if (h >= HA / 2 - PS / 2 && h < HA / 2 - PS / 2 + PS &&
            v >= VA / 2 - PS / 2 && v < VA / 2 - PS / 2 + PS) p = 24'hE0A080;
`endif
        return p;
    endfunction

    logic [23:0] e_data;
    logic        e_hs, e_vs, e_vde, e_fs;
    logic [7:0]  e_cnt;
    bit          m_valid = 1'b0;
    bit          m_run;
    bit          m_first;
    int          m_p;
    int          m_pat;

    always @(posedge clk) begin : p_model
        int h;
        int v;
        if (rst || !i_en || !m_run) begin
            e_data = 24'h0; e_hs = ~POL; e_vs = ~POL; e_vde = 1'b0; e_fs = 1'b0;
            if (rst) begin
                m_run = 1'b0; m_p = 0; m_pat = 0; m_first = 1'b1; e_cnt = 8'd0;
            end else if (!i_en) begin
                m_run = 1'b0; m_p = 0; m_first = 1'b1;
            end else begin
                m_run = 1'b1;
            end
        end else begin
            h      = m_p % HT;
            v      = m_p / HT;
            e_vde  = (h < HA) && (v < VA);
            e_data = f_pixel(h, v, m_pat, i_solid_rgb);
            e_hs   = (h >= HA + HF && h < HA + HF + HS) ? POL : ~POL;
            e_vs   = (v >= VA + VF && v < VA + VF + VS) ? POL : ~POL;
            e_fs   = (m_p == 0);
            if (m_p == 0) begin
                if (m_first) m_first = 1'b0;
                else         e_cnt   = e_cnt + 8'd1;
            end
            if (m_p == FT - 1) m_pat = int'(i_pattern_sel);
            m_p = (m_p + 1) % FT;
        end
        m_valid = 1'b1;
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("data",   o_vid_data,    e_data);
            chk("hsync",  o_vid_hsync,   e_hs);
            chk("vsync",  o_vid_vsync,   e_vs);
            chk("VDE",    o_vid_VDE,     e_vde);
            chk("fstart", o_frame_start, e_fs);
            chk("fcnt",   o_frame_cnt,   e_cnt);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus with literal checks (driven on falling edges)
    // ------------------------------------------------------------------
    int cur;

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Advance until the outputs show linear pixel p of the current run.
    task automatic goto_pix(input int p);
        step(p - cur);
        cur = p;
    endtask

    // Release reset/enable and land on pixel 0 of the first frame.
    task automatic start_run();
        rst  = 1'b0;
        i_en = 1'b1;
        step(2);
        cur = 0;
    endtask

    initial begin
        rst = 1'b1; i_en = 1'b1; i_pattern_sel = 2'd0; i_solid_rgb = 24'h123456;
        step(3);
        chk("rst_data",  o_vid_data,  24'h000000);
        chk("rst_vde",   o_vid_VDE,   1'b0);
        chk("rst_hs",    o_vid_hsync, 1'b0);
        chk("rst_vs",    o_vid_vsync, 1'b0);
        chk("rst_cnt",   o_frame_cnt, 8'd0);
        rst = 1'b0;
        step(1);
        chk("arm_vde",   o_vid_VDE,   1'b0);
        step(1);
        cur = 0;
        chk("p0_vde",    o_vid_VDE,     1'b1);
        chk("p0_fs",     o_frame_start, 1'b1);
        chk("p0_data",   o_vid_data,    24'hFFFFFF);
        goto_pix(1);  chk("bar_x1",  o_vid_data, 24'hFFFFFF);
        goto_pix(2);  chk("bar_x2",  o_vid_data, 24'hFFFF00);
        goto_pix(13); chk("bar_x13", o_vid_data, 24'h0000FF);
        goto_pix(14); chk("bar_x14", o_vid_data, 24'h000000);
        goto_pix(15); chk("vde_x15", o_vid_VDE,  1'b1);
        goto_pix(16); chk("blank_vde", o_vid_VDE, 1'b0);
                      chk("blank_data", o_vid_data, 24'h000000);
        goto_pix(17); chk("hs_x17", o_vid_hsync, 1'b0);
        goto_pix(18); chk("hs_x18", o_vid_hsync, 1'b1);
        goto_pix(19); chk("hs_x19", o_vid_hsync, 1'b1);
        goto_pix(20); chk("hs_x20", o_vid_hsync, 1'b0);
        goto_pix(8 * HT);     chk("vs_l8", o_vid_vsync, 1'b0);
        goto_pix(9 * HT + 3); chk("vs_l9", o_vid_vsync, 1'b1);
        goto_pix(10 * HT);    chk("vs_l10", o_vid_vsync, 1'b0);
        goto_pix(FT - 1);     chk("fs_241", o_frame_start, 1'b0);
        goto_pix(FT);         chk("fs_242", o_frame_start, 1'b1);
                              chk("cnt_f2", o_frame_cnt, 8'd1);
        // Mid-frame pattern change must not tear the frame.
        goto_pix(FT + 3 * HT + 4); i_pattern_sel = 2'd2;
        goto_pix(FT + 4 * HT + 5); chk("bars_hold", o_vid_data, 24'h00FFFF);
        goto_pix(2 * FT);          chk("fs_484", o_frame_start, 1'b1);
                                   chk("cnt_f3", o_frame_cnt, 8'd2);
        goto_pix(2 * FT + 5);      chk("grey_x5", o_vid_data, 24'h050505);
        goto_pix(2 * FT + 100);    i_pattern_sel = 2'd0;
        goto_pix(3 * FT);          chk("f4_data", o_vid_data, 24'hFFFFFF);
                                   chk("cnt_f4", o_frame_cnt, 8'd3);
        // Drop enable while the counter is at (7,2).
        goto_pix(3 * FT + 2 * HT + 6);
        i_en = 1'b0;
        step(1);
        chk("dis_vde",  o_vid_VDE,     1'b0);
        chk("dis_data", o_vid_data,    24'h000000);
        chk("dis_fs",   o_frame_start, 1'b0);
        chk("dis_cnt",  o_frame_cnt,   8'd3);
        step(3);
        start_run();
        chk("re_fs",   o_frame_start, 1'b1);
        chk("re_data", o_vid_data,    24'hFFFFFF);
        chk("re_cnt",  o_frame_cnt,   8'd3);
        goto_pix(2); chk("re_x2", o_vid_data, 24'hFFFF00);

        // Checkerboard (and patch when enabled): frame 1 bars, frame 2 checker.
        rst = 1'b1; i_pattern_sel = 2'd1;
        step(2);
        start_run();
        goto_pix(FT + 2);
        chk("ck_2_0", o_vid_data, 24'hFFFFFF);
        goto_pix(FT + 2 * HT + 5);  chk("ck_5_2",  o_vid_data, 24'h000000);
`ifdef SKIN_PATCH_EN
        goto_pix(FT + 2 * HT + 6);  chk("pt_6_2",  o_vid_data, 24'hE0A080);
`else
        goto_pix(FT + 2 * HT + 6);  chk("ck_6_2",  o_vid_data, 24'h000000);
`endif
        goto_pix(FT + 2 * HT + 10); chk("ck_10_2", o_vid_data, 24'hFFFFFF);
`ifdef SKIN_PATCH_EN
        goto_pix(FT + 5 * HT + 9);  chk("pt_9_5",  o_vid_data, 24'hE0A080);
`else
        goto_pix(FT + 5 * HT + 9);  chk("ck_9_5",  o_vid_data, 24'h000000);
`endif
        goto_pix(FT + 6 * HT + 9);  chk("ck_9_6",  o_vid_data, 24'h000000);

        // Randomised run: pattern/colour every cycle, rare disables/resets.
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        for (int i = 0; i < 6000; i++) begin
            @(negedge clk);
            i_pattern_sel = 2'($urandom_range(0, 3));
            i_solid_rgb   = 24'($urandom);
            i_en          = ($urandom_range(0, 799) != 0);
            rst           = ($urandom_range(0, 2999) == 0);
        end
        rst = 1'b0; i_en = 1'b1;
        step(2);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vid_pattern_gen.md
Name: vid_pattern_gen

Overview:
Video stream source that produces the same pixel/sync/VDE interface the pixel-processing blocks consume. It is the transmitter end of the stream.
- Generates raster timing (hsync, vsync, VDE) from programmable counters.
- Drives 24-bit pixel data from a selectable test pattern.
- Lets downstream filters (e.g. skin-tone detection) run on a known stream without HDMI input.

Parameters:
- H_ACTIVE, 1280: active pixels per line
- H_FP, 110: horizontal front porch, in pixels
- H_SYNC, 40: hsync width, in pixels
- H_BP, 220: horizontal back porch, in pixels
- V_ACTIVE, 720: active lines per frame
- V_FP, 5: vertical front porch, in lines
- V_SYNC, 5: vsync width, in lines
- V_BP, 20: vertical back porch, in lines
- SYNC_POL, 1: active level of hsync/vsync
- CHECK_LOG2, 5: checkerboard square size is 2^CHECK_LOG2 pixels
- PATCH_SIZE, 64: side length of the optional skin patch, in pixels/lines

Ports:
- clk  in  1  pixel clock
- rst  in  1  synchronous, active-high reset
- i_en  in  1  generator enable
- i_pattern_sel  in  2  0 = colour bars, 1 = checkerboard, 2 = grey gradient, 3 = solid colour
- i_solid_rgb  in  24  colour used by pattern 3
- o_vid_data  out  24  pixel: [23:16] R, [15:8] G, [7:0] B
- o_vid_hsync  out  1  horizontal sync
- o_vid_vsync  out  1  vertical sync
- o_vid_VDE  out  1  active video
- o_frame_start  out  1  one-cycle pulse coincident with pixel (0,0)
- o_frame_cnt  out  8  completed-frame counter

Behaviour:
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
- Counter h runs 0..H_TOTAL-1; at wrap, v increments, range 0..V_TOTAL-1.
- Line order: active, FP, sync, BP. Frame order is the same.
- Counters advance only while i_en=1.
- Reset values while rst=1:
  - h=v=0, o_vid_data=0, VDE=0, hsync=vsync=~SYNC_POL
  - o_frame_start=0, o_frame_cnt=0, latched pattern=0
- Output latency: all outputs are registered and reflect the counter state one cycle earlier.
  - Edge 1 after rst release with i_en=1: counter is at (0,0).
  - Edge 2: outputs show pixel (0,0) and o_frame_start=1.
- VDE = (h<H_ACTIVE) && (v<V_ACTIVE).
- hsync = SYNC_POL when H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC; otherwise ~SYNC_POL.
- vsync uses the same rule on v, for whole lines.
- o_vid_data = 0 whenever VDE=0.
- Pattern select:
  - i_pattern_sel is latched only on the last counter state of a frame (h=H_TOTAL-1, v=V_TOTAL-1).
  - A mid-frame change never tears a frame.
- Pattern 0, colour bars:
  - bar width W = H_ACTIVE/8 (integer); bar index = min(h/W, 7).
  - Colours in order: FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000.
  - Implement h/W as a counter that resets each line, not a divider.
- Pattern 1, checkerboard: FFFFFF if h[CHECK_LOG2]^v[CHECK_LOG2]=0, else 000000.
- Pattern 2, grey gradient: R=G=B=h[7:0]; wraps every 256 pixels.
- Pattern 3: i_solid_rgb, sampled live.
- o_frame_cnt increments (mod 256) in the same cycle o_frame_start pulses, except for the first frame after reset or re-enable.
- i_en=1->0 (including mid-line):
  - Next edge: counters return to (0,0) and outputs go to reset values; o_frame_cnt holds.
  - Restarting sets o_frame_start on the first output pixel, exactly as after reset.
- rst has priority over i_en.
- Reset mid-frame aborts the frame; no partial sync pulse is extended.

Optional Feature:
- Macro: SKIN_PATCH_EN.
- When defined:
  - A PATCH_SIZE x PATCH_SIZE square overrides the selected pattern with E0A080 (R=224, G=160, B=128).
  - Square position: x0 = H_ACTIVE/2-PATCH_SIZE/2, y0 = V_ACTIVE/2-PATCH_SIZE/2.
  - Applies for x0 <= h < x0+PATCH_SIZE and y0 <= v < y0+PATCH_SIZE, active region only.
  - Same one-cycle latency; gives downstream skin detection a known positive target.
- When undefined: no patch logic is present and pattern output is unmodified.

Test Plan:
All scenarios use small timing: H 16/2/2/2 (H_TOTAL=22), V 8/1/1/1 (V_TOTAL=11), SYNC_POL=1.
1. rst high 3 cycles with i_en=1 -> data=000000, VDE=0, hsync=vsync=0, frame_cnt=0. Release -> second edge shows VDE=1, frame_start=1.
2. Free run 3 frames ->
   - VDE high 16 consecutive cycles per line, 8 lines per frame.
   - hsync high at h=18,19.
   - vsync high for all of line 9.
   - frame_start every 242 cycles; frame_cnt reads 2 during the third frame.
3. Pattern 0 -> x=0,1 FFFFFF; x=2,3 FFFF00; ... x=14,15 000000; data=0 during blanking.
4. Set i_pattern_sel=2 during line 3 -> rest of frame stays bars; next frame x=5 gives 050505.
5. Drop i_en at h=7, v=2 for 4 cycles -> outputs idle the next cycle. Re-enable -> frame_start on first pixel, pattern restarts at (0,0), frame_cnt unchanged.
6. SKIN_PATCH_EN, PATCH_SIZE=4, pattern 1 -> pixels x=6..9, y=2..5 read E0A080; x=5 and x=10 follow the checkerboard.
